// File: rtl/vote_tally_multi_pkg.sv
// Shared types and helpers for the multi-candidate vote tally.
// State enum, hold-counter sizing, winner/tie search.
package vote_tally_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTE   = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int MAX_CAND  = 16;
  localparam int MAX_CNT_W = 32;

  // Hold counter counts 0..HOLD_CYC-1.
  function automatic int hold_w(input int hold_cyc);
    return (hold_cyc < 2) ? 1 : $clog2(hold_cyc);
  endfunction

  localparam int HOLD_CYC_DEF = 16;
  localparam int HOLD_W_DEF   = hold_w(HOLD_CYC_DEF);

  typedef logic [MAX_CAND-1:0][MAX_CNT_W-1:0] tally_arr_t;

  typedef struct packed {
    logic [3:0] idx;
    logic       tie;
  } win_t;

  // Lowest index holding the maximum; tie if the
  // maximum is shared (all-zero counts as a tie).
  function automatic win_t find_winner(
    input tally_arr_t t,
    input int         n
  );
    win_t                 w;
    logic [MAX_CNT_W-1:0] best;
    w.idx = '0;
    w.tie = 1'b0;
    best  = t[0];
    for (int k = 1; k < MAX_CAND; k++) begin
      if (k < n) begin
        if (t[k] > best) begin
          best  = t[k];
          w.idx = 4'(k);
          w.tie = 1'b0;
        end else if (t[k] == best) begin
          w.tie = 1'b1;
        end
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/vote_tally_multi_if.sv
// Handshake bundle between buttons/readout and the tally.
// master drives i_*, slave (the tally) drives o_*.
interface vote_tally_if #(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 16
);
  localparam int WIN_W = $clog2(N_CAND);

  logic                    i_start;
  logic [N_CAND-1:0]       i_vote;
  logic                    i_voting_over;
  logic [N_CAND*CNT_W-1:0] o_tally;
  logic                    o_valid;
  logic                    o_busy;
  logic                    o_accept;
  logic                    o_reject;
  logic [WIN_W-1:0]        o_winner;
  logic                    o_tie;

  modport master (
    output i_start, i_vote, i_voting_over,
    input  o_tally, o_valid, o_busy,
    input  o_accept, o_reject, o_winner, o_tie
  );

  modport slave (
    input  i_start, i_vote, i_voting_over,
    output o_tally, o_valid, o_busy,
    output o_accept, o_reject, o_winner, o_tie
  );
endinterface

// File: rtl/vote_tally_multi_release.sv
// Release edge detector: prev register + one-hot/multi decode.
// Ports: clk, rst, i_vote in; rel, rel_one, rel_multi out.
module vote_release_detect #(
  parameter int N_CAND = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CAND-1:0] i_vote,
  output logic [N_CAND-1:0] rel,
  output logic              rel_one,
  output logic              rel_multi
);

  logic [N_CAND-1:0] prev_q;
  logic [N_CAND-1:0] low_cl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= '1;
    else      prev_q <= i_vote;
  end

  assign rel = prev_q & ~i_vote;

  // Clearing the lowest set bit leaves something
  // only if two or more bits were set.
  assign low_cl    = rel & (rel - N_CAND'(1));
  assign rel_multi = |low_cl;
  assign rel_one   = (|rel) & ~rel_multi;

endmodule

// File: rtl/vote_tally_multi.sv
// Multi-candidate vote tally: FSM, counters, lockout, publish.
// Ports: clk, rst (async low), bus (vote_tally_if.slave).
// Winner/tie logic built only with VOTE_TALLY_WINNER_EN.
module vote_tally_multi
  import vote_tally_pkg::*;
#(
  parameter int N_CAND   = 4,
  parameter int CNT_W    = 16,
  parameter int HOLD_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  vote_tally_if.slave  bus
);

  localparam int HOLD_W = hold_w(HOLD_CYC);
  localparam int WIN_W  = $clog2(N_CAND);

  state_e                        state_q;
  logic [N_CAND-1:0][CNT_W-1:0]  cnt_q;
  logic [N_CAND-1:0][CNT_W-1:0]  cnt_d;
  logic [HOLD_W-1:0]             hold_q;
  logic [N_CAND*CNT_W-1:0]       tally_q;
  logic                          valid_q;
  logic                          busy_q;
  logic                          acc_q;
  logic                          rej_q;

  logic [N_CAND-1:0]             rel;
  logic                          rel_one;
  logic                          rel_multi;
  logic                          active;
  logic                          fin_entry;

  vote_release_detect #(
    .N_CAND (N_CAND)
  ) u_rel (
    .clk       (clk),
    .rst       (rst),
    .i_vote    (bus.i_vote),
    .rel       (rel),
    .rel_one   (rel_one),
    .rel_multi (rel_multi)
  );

  assign active    = (state_q == VOTE) || (state_q == HOLD);
  assign fin_entry = active && bus.i_voting_over;

  // Saturating +1 for the released candidate only.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < N_CAND; k++) begin
      if (rel[k] && (cnt_q[k] != '1))
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      tally_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      acc_q <= 1'b0;
      rej_q <= 1'b0;
      if (fin_entry) begin
        // Close wins over any same-cycle release.
        state_q <= FINISH;
        tally_q <= cnt_q;
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.i_start) begin
              state_q <= VOTE;
              cnt_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          VOTE: begin
            if (rel_one) begin
              cnt_q   <= cnt_d;
              acc_q   <= 1'b1;
              hold_q  <= '0;
              state_q <= HOLD;
            end else if (rel_multi) begin
              rej_q <= 1'b1;
            end
          end
          HOLD: begin
            if (hold_q == HOLD_W'(HOLD_CYC - 1))
              state_q <= VOTE;
            else
              hold_q <= hold_q + HOLD_W'(1);
          end
          FINISH: begin
            if (!bus.i_voting_over)
              state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_tally  = tally_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_accept = acc_q;
  assign bus.o_reject = rej_q;

`ifdef VOTE_TALLY_WINNER_EN
  tally_arr_t       arr;
  win_t             win;
  logic [WIN_W-1:0] win_q;
  logic             tie_q;

  always_comb begin
    arr = '0;
    for (int k = 0; k < N_CAND; k++)
      arr[k] = MAX_CNT_W'(cnt_q[k]);
    win = find_winner(arr, N_CAND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q <= '0;
      tie_q <= 1'b0;
    end else if (fin_entry) begin
      win_q <= WIN_W'(win.idx);
      tie_q <= win.tie;
    end
  end

  assign bus.o_winner = win_q;
  assign bus.o_tie    = tie_q;
`else
  assign bus.o_winner = '0;
  assign bus.o_tie    = 1'b0;
`endif

endmodule

// File: doc/vote_tally_multi.md
# vote_tally_multi

Parametrised successor to the three-candidate voting machine. It counts button-release votes for N_CAND candidates with per-candidate saturating counters, rejects ambiguous simultaneous votes, and enforces a programmable post-vote lockout. On close it publishes the tallies and an optional winner/tie indication. It sits between the debounced candidate push-buttons and the result display/readout logic.

## Interface
- N_CAND, 4: number of candidates, 2..16.
- CNT_W, 16: width of each tally counter.
- HOLD_CYC, 16: lockout cycles after an accepted vote, 1..65535.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  opens a voting session (sampled in IDLE only).
- i_vote  in  N_CAND  candidate buttons; a vote is a 1->0 release.
- i_voting_over  in  1  closes the session; level-sensitive.
- o_tally  out  N_CAND*CNT_W  published tallies; candidate k at bits [k*CNT_W +: CNT_W].
- o_valid  out  1  high while o_tally holds a completed session's result.
- o_busy  out  1  high in VOTE or HOLD.
- o_accept  out  1  one-cycle pulse per counted vote.
- o_reject  out  1  one-cycle pulse per rejected multi-release.
- o_winner  out  $clog2(N_CAND)  index of the winning candidate.
- o_tie  out  1  at least two candidates share the maximum tally.

## Operation
- States: IDLE, VOTE, HOLD, FINISH.
- IDLE to VOTE on i_start=1. On this transition the internal counters clear to 0. o_tally and o_valid are left unchanged.
- In VOTE, release detection: rel[k] = prev[k] & ~i_vote[k]. prev[k] registers i_vote[k] every cycle, in all states.
- Exactly one rel bit set: counter k += 1, saturating at 2^CNT_W-1. o_accept pulses. Go to HOLD with the hold counter at 0.
- Two or more rel bits set: no count, o_reject pulses, stay in VOTE.
- No rel bits set: stay in VOTE.
- HOLD: the hold counter increments each cycle. Releases are ignored (not counted, not rejected). After HOLD_CYC cycles, return to VOTE.
- i_voting_over=1 in VOTE or HOLD goes to FINISH and takes priority over any same-cycle release (that release is not counted). i_voting_over is ignored in IDLE.
- On entering FINISH: o_tally <= counters, o_valid <= 1, and winner/tie are computed from the counters.
- FINISH to IDLE when i_voting_over=0. Outputs hold their values.
- i_start=1 in IDLE clears o_valid on the VOTE transition. o_tally keeps the last result until the next FINISH.
- Winner is the lowest index with the maximum tally. o_tie=1 if two or more candidates equal that maximum, including the all-zero case.

## Timing
- Reset values: state IDLE, counters 0, prev all 1, o_tally 0, o_valid 0, o_busy 0, o_accept 0, o_reject 0, o_winner 0, o_tie 0.
- Release in cycle t (input low at edge t, prev high) updates the counter and raises o_accept at edge t+1.
- HOLD lasts exactly HOLD_CYC cycles. The earliest next counted release is sampled HOLD_CYC+1 cycles after the accepting edge.
- i_voting_over high at edge t: o_tally and o_valid are updated at edge t+1 and o_busy drops at edge t+1.
- Asynchronous reset mid-session discards all counts immediately, including the published o_tally.
- Counter saturation is silent: o_accept still pulses and the tally stays at maximum.

## Configuration
- VOTE_TALLY_WINNER_EN defined: winner and tie comparison logic is built, as described above. The comparison is registered at the FINISH entry.
- VOTE_TALLY_WINNER_EN undefined: no comparison logic is built; o_winner and o_tie are tied to 0.

## Structure
- Package vote_tally_pkg holds:
  - the state enum (IDLE, VOTE, HOLD, FINISH), 2 bits;
  - the localparam for the hold-counter width, derived from HOLD_CYC;
  - a helper function that computes the max index and tie flag over a packed tally vector.
- Sub-module vote_release_detect: the N_CAND-wide prev register plus release/onehot/multi decode. Outputs are rel, rel_one and rel_multi.
- The top level holds the FSM, the counter array, the hold counter and the publish registers.

## Test plan
- N_CAND=4, HOLD_CYC=4: release candidate 2 once -> o_accept pulses once. After close, tally[2]=1, others 0, o_winner=2, o_tie=0.
- Release candidates 0 and 3 in the same cycle -> o_reject=1 for one cycle, no count, state stays VOTE.
- Release candidate 1, then candidate 1 again 2 cycles later (inside HOLD) -> only 1 counted. A third release 6 cycles after the first -> tally[1]=2.
- CNT_W=3: release candidate 0 nine times with spacing > HOLD_CYC -> tally[0]=7 (saturated), o_accept pulsed 9 times.
- Two votes each for candidates 1 and 3, then close -> o_winner=1, o_tie=1. With the macro undefined -> o_winner=0, o_tie=0.
- Drive rst low while in HOLD with tallies of 3 -> all outputs reset immediately. After reset release, i_start and one vote then close -> tally shows only 1.
